fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter PC_INIT, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 The module SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 The module SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 The module SHALL have port ihit  input  1  instruction memory hit; iload valid this cycle.
REQ-005 The module SHALL have port iload  input  32  instruction word from instruction memory.
REQ-006 The module SHALL have port stall  input  1  datapath data-memory stall, high while a dREN/dWEN request is pending without dhit.
REQ-007 The module SHALL have port halt  input  1  halt decoded by the control unit from imemload.
REQ-008 The module SHALL have port JumpSel  input  2  PC source select from the control unit.
REQ-009 The module SHALL have port PCsrc  input  1  branch instruction flag from the control unit.
REQ-010 The module SHALL have port BNE  input  1  branch sense: 1 = branch on not-equal, 0 = branch on equal.
REQ-011 The module SHALL have port zero  input  1  ALU zero flag for the current instruction.
REQ-012 The module SHALL have port rdat1  input  32  register Rs value, the JR target.
REQ-013 The module SHALL have port iREN  output  1  instruction memory read enable.
REQ-014 The module SHALL have port iaddr  output  32  instruction memory address.
REQ-015 The module SHALL have port imemload  output  32  registered instruction presented to the control unit.
REQ-016 The module SHALL have port instr_valid  output  1  imemload is the instruction under execution.
REQ-017 The module SHALL have port pc  output  32  address of the instruction in imemload.
REQ-018 The module SHALL have port pc_plus4  output  32  pc + 4, the JAL link value.
REQ-019 The module SHALL have port halted  output  1  sticky halt indication.

Function
REQ-020 The module SHALL implement states FETCH, EXEC and HALT.
REQ-021 In FETCH the module SHALL drive iREN=1 and iaddr=pc, and SHALL remain in FETCH while ihit=0.
REQ-022 In FETCH with ihit=1, the module SHALL load iload into imemload and go to EXEC on the next edge; latency from ihit to instr_valid is 1 cycle.
REQ-023 In EXEC and HALT the module SHALL drive iREN=0 and hold iaddr=pc.
REQ-024 instr_valid SHALL be 1 exactly when the state is EXEC.
REQ-025 In EXEC with stall=1, the module SHALL hold the state, pc and imemload unchanged.
REQ-026 In EXEC with stall=0 and halt=1, the module SHALL go to HALT with pc unchanged.
REQ-027 In EXEC with stall=0 and halt=0, the module SHALL load pc with next_pc and go to FETCH.
REQ-028 next_pc SHALL be selected by JumpSel: 00 selects seq_pc, 01 selects {pc_plus4[31:28], imemload[25:0], 2'b00}, 10 selects rdat1, and 11 selects pc_plus4.
REQ-029 seq_pc SHALL equal pc_plus4 + (sign-extended imemload[15:0] << 2) when PCsrc=1 and (BNE ? !zero : zero) holds, and SHALL equal pc_plus4 otherwise.
REQ-030 All PC arithmetic SHALL be 32-bit modulo: 32'hFFFFFFFC + 4 = 32'h00000000, with no flag raised.
REQ-031 rdat1 SHALL be used unmodified, with no alignment check.
REQ-032 HALT SHALL be absorbing: only RST leaves it, halted=1, and ihit, stall and halt are ignored.
REQ-033 ihit SHALL be ignored outside FETCH.
REQ-034 halt, JumpSel, PCsrc, BNE and zero SHALL be ignored outside EXEC.
REQ-035 pc_plus4 SHALL be combinational pc + 4 in every state.

Reset
REQ-036 While RST=1 at a rising edge, the module SHALL set the state to FETCH, pc=PC_INIT, imemload=32'h00000000 and halted=0, overriding every other input, including RST asserted mid-EXEC or in HALT.
REQ-037 On the first cycle after reset, the module SHALL drive iREN=1, iaddr=PC_INIT and instr_valid=0.

Verification
REQ-038 Bench SHALL cover this reset-and-fetch scenario: RST for 2 cycles, then ihit=1 after 3 wait cycles with iload=32'h20010005 -> iREN=1 and iaddr=0 for 4 cycles; then imemload=32'h20010005, instr_valid=1, pc=0; with stall=0 and JumpSel=00, pc=4 with FETCH re-entered.
REQ-039 Bench SHALL cover taken and untaken branches: at pc=32'h10, imemload[15:0]=16'hFFFE, PCsrc=1, BNE=0 -> zero=1 gives next pc=32'h0C and zero=0 gives 32'h14; with BNE=1 the outcomes invert.
REQ-040 Bench SHALL cover jumps: at pc=32'hF000_0040, JumpSel=01, imemload[25:0]=26'h0000100 -> pc=32'hF000_0400; JumpSel=10, rdat1=32'h0000_0123 -> pc=32'h0000_0123.
REQ-041 Bench SHALL cover a data stall: EXEC with stall=1 for 5 cycles -> pc, imemload and instr_valid=1 are held and iREN=0; stall=0 then advances pc once.
REQ-042 Bench SHALL cover halt: halt=1 with stall=0 in EXEC -> halted=1 and iREN=0 from the next cycle, with pc unchanged; ihit pulses are ignored; RST then returns to FETCH with pc=PC_INIT and halted=0.
REQ-043 Bench SHALL cover wrap and mid-operation reset: pc=32'hFFFFFFFC with JumpSel=00 -> pc=0; RST asserted in EXEC with stall=1 -> FETCH, pc=PC_INIT and imemload=0 next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit for a multicycle datapath.
// Fetches one instruction per FETCH phase, presents it to the control unit
// during EXEC, then computes the next PC (sequential, branch, jump, JR).
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        stall,
  input  logic        halt,
  input  logic [1:0]  JumpSel,
  input  logic        PCsrc,
  input  logic        BNE,
  input  logic        zero,
  input  logic [31:0] rdat1,
  output logic        iREN,
  output logic [31:0] iaddr,
  output logic [31:0] imemload,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] imemload_q, imemload_d;

  logic [31:0] pc_plus4_w;
  logic [31:0] branch_off;
  logic [31:0] seq_pc;
  logic [31:0] jump_pc;
  logic [31:0] next_pc;
  logic        branch_taken;

  // Next-PC datapath; all adds wrap modulo 2^32 with no overflow indication.
  always_comb begin
    pc_plus4_w   = pc_q + 32'd4;
    branch_off   = {{14{imemload_q[15]}}, imemload_q[15:0], 2'b00};
    branch_taken = PCsrc & (BNE ? ~zero : zero);
    seq_pc       = branch_taken ? (pc_plus4_w + branch_off) : pc_plus4_w;
    jump_pc      = {pc_plus4_w[31:28], imemload_q[25:0], 2'b00};
    case (JumpSel)
      2'b00:   next_pc = seq_pc;
      2'b01:   next_pc = jump_pc;
      2'b10:   next_pc = rdat1;     // JR target taken as-is, no alignment check
      default: next_pc = pc_plus4_w;
    endcase
  end

  // Next-state logic: FETCH waits for ihit, EXEC waits out data stalls,
  // HALT is absorbing until reset.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    imemload_d = imemload_q;
    case (state_q)
      FETCH: begin
        if (ihit) begin
          imemload_d = iload;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          if (halt) begin
            state_d = HALT;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State registers; reset overrides every other input in every state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= FETCH;
      pc_q       <= PC_INIT;
      imemload_q <= 32'h00000000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      imemload_q <= imemload_d;
    end
  end

  // Output decode from the registered state.
  always_comb begin
    iREN        = (state_q == FETCH);
    iaddr       = pc_q;
    imemload    = imemload_q;
    instr_valid = (state_q == EXEC);
    pc          = pc_q;
    pc_plus4    = pc_plus4_w;
    halted      = (state_q == HALT);
  end

endmodule
